// File: rtl/ace_fetch_pkg.sv
// Shared fetch-pipeline definitions: sequencer state encodings, PC alignment
// helpers and the redirect source enum also used by the fetch debug trace.
package ace_fetch_pkg;

   localparam logic [1:0] BOOT   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] STALL  = 2'd2;
   localparam logic [1:0] BUBBLE = 2'd3;

   localparam logic [63:0] PC_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

   typedef enum logic [1:0] {
      SRC_FLUSH = 2'd0,
      SRC_OVR   = 2'd1,
      SRC_HOLD  = 2'd2,
      SRC_SEQ   = 2'd3
   } redirSrc_e;

   function automatic logic [63:0] alignPc(input logic [63:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/ace_perf_cnt.sv
// Enable-gated performance counter; wraps silently at 2^CNT_W.
module ace_perf_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ace_pcgen.sv
// Fetch PC generator: sequences the F0/F1 fetch PCs and selects each cycle's
// redirect source (retire flush, F1 override, hold, or F0 prediction).
module ace_pcgen
   import ace_fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC     = 64'h0,
   parameter int unsigned FLUSH_BUBBLE = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush_rt_i,
   input  logic [63:0]      flush_pc_rt_i,
   input  logic             override_vld_f1_i,
   input  logic [63:0]      override_pc_f1_i,
   input  logic [63:0]      nxt_pc_f0_i,
   input  logic             icache_stall_i,
   input  logic             instbuf_full_i,
   input  logic             bob_stall_i,
   output logic [63:0]      pc_f0_o,
   output logic [63:0]      pc_f1_o,
   output logic             f0_vld_o,
   output logic             f1_vld_o,
   output logic             icache_req_o,
   output logic             fill_f1_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] override_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam logic [1:0] BUBBLE_LOAD = 2'(FLUSH_BUBBLE);

   logic [63:0] pcF0_q, pcF0_d;
   logic [63:0] pcF1_q, pcF1_d;
   logic        f0Vld_q, f0Vld_d;
   logic        f1Vld_q, f1Vld_d;
   logic [1:0]  state_q, state_d;
   logic [1:0]  bubbleCnt_q, bubbleCnt_d;
   logic        hold;
   logic        booting;
   redirSrc_e   redirSrc;

   assign hold         = instbuf_full_i | bob_stall_i | icache_stall_i;
   assign booting      = (state_q == BOOT);
   assign fill_f1_o    = (~hold | flush_rt_i) & ~booting;
   assign icache_req_o = f0Vld_q & ~booting;

   always_comb begin
      if (flush_rt_i) begin
         redirSrc = SRC_FLUSH;
      end else if (override_vld_f1_i) begin
         redirSrc = SRC_OVR;
      end else if (hold) begin
         redirSrc = SRC_HOLD;
      end else begin
         redirSrc = SRC_SEQ;
      end
   end

   // A hold inside BUBBLE stays in BUBBLE so the drain count is only frozen,
   // never lost; only advance cycles consume bubble slots.
   always_comb begin
      pcF0_d      = pcF0_q;
      pcF1_d      = pcF1_q;
      f0Vld_d     = f0Vld_q;
      f1Vld_d     = f1Vld_q;
      state_d     = state_q;
      bubbleCnt_d = bubbleCnt_q;
      if (booting) begin
         state_d = RUN;
         f0Vld_d = 1'b1;
      end else begin
         case (redirSrc)
            SRC_FLUSH: begin
               pcF0_d      = alignPc(flush_pc_rt_i);
               f0Vld_d     = 1'b1;
               f1Vld_d     = 1'b0;
               bubbleCnt_d = BUBBLE_LOAD;
               state_d     = BUBBLE;
            end
            SRC_OVR: begin
               pcF0_d  = alignPc(override_pc_f1_i);
               f1Vld_d = 1'b0;
               state_d = RUN;
            end
            SRC_HOLD: begin
               if (state_q != BUBBLE) begin
                  state_d = STALL;
               end
            end
            default: begin
               pcF1_d  = pcF0_q;
               f1Vld_d = f0Vld_q;
               pcF0_d  = alignPc(nxt_pc_f0_i);
               state_d = RUN;
               if (state_q == BUBBLE && bubbleCnt_q != 2'd0) begin
                  f1Vld_d     = 1'b0;
                  bubbleCnt_d = bubbleCnt_q - 2'd1;
                  state_d     = (bubbleCnt_q == 2'd1) ? RUN : BUBBLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pcF0_q      <= RESET_PC;
         pcF1_q      <= '0;
         f0Vld_q     <= 1'b0;
         f1Vld_q     <= 1'b0;
         state_q     <= BOOT;
         bubbleCnt_q <= 2'd0;
      end else begin
         pcF0_q      <= pcF0_d;
         pcF1_q      <= pcF1_d;
         f0Vld_q     <= f0Vld_d;
         f1Vld_q     <= f1Vld_d;
         state_q     <= state_d;
         bubbleCnt_q <= bubbleCnt_d;
      end
   end

   assign pc_f0_o  = pcF0_q;
   assign pc_f1_o  = pcF1_q;
   assign f0_vld_o = f0Vld_q;
   assign f1_vld_o = f1Vld_q;

   logic flushEn, ovrEn, stallEn;

   assign flushEn = ~booting & (redirSrc == SRC_FLUSH);
   assign ovrEn   = ~booting & (redirSrc == SRC_OVR);
   assign stallEn = ~booting & (redirSrc == SRC_HOLD);

   ace_perf_cnt #(.CNT_W(CNT_W)) uFlushCnt (
      .clock   (clock),
      .reset_n (reset_n),
      .en_i    (flushEn),
      .cnt_o   (flush_cnt_o)
   );

   ace_perf_cnt #(.CNT_W(CNT_W)) uOvrCnt (
      .clock   (clock),
      .reset_n (reset_n),
      .en_i    (ovrEn),
      .cnt_o   (override_cnt_o)
   );

   ace_perf_cnt #(.CNT_W(CNT_W)) uStallCnt (
      .clock   (clock),
      .reset_n (reset_n),
      .en_i    (stallEn),
      .cnt_o   (stall_cnt_o)
   );

endmodule
